// File: rtl/halut_encoder.sv
// HALUT encoder: per codebook, walks a binary decision tree of FP16 threshold compares
// and streams out (codebook, prototype) index pairs with valid/ready handshaking.
module halut_encoder #(
    parameter int K              = 16,
    parameter int C              = 32,
    parameter int DataTypeWidth  = 16,
    parameter int TreeDepth      = $clog2(K),
    parameter int CAddrWidth     = $clog2(C),
    parameter int TotalAddrWidth = $clog2(C * K)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [TotalAddrWidth-1:0]          waddr_i,
    input  logic [DataTypeWidth-1:0]           wdata_i,
    input  logic                               we_i,
    input  logic [TreeDepth*DataTypeWidth-1:0] x_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    output logic [CAddrWidth-1:0]              c_addr_o,
    output logic [TreeDepth-1:0]               k_addr_o,
    output logic                               valid_o,
    output logic                               last_o,
    input  logic                               ready_i
);

    localparam int LevelWidth = (TreeDepth > 1) ? $clog2(TreeDepth) : 1;
    localparam logic [LevelWidth-1:0]    LastLevel = LevelWidth'(TreeDepth - 1);
    localparam logic [CAddrWidth-1:0]    LastC     = CAddrWidth'(C - 1);
    localparam logic [DataTypeWidth-1:0] SignMask  = {1'b1, {(DataTypeWidth-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [DataTypeWidth-1:0] x_reg   [TreeDepth];
    logic [DataTypeWidth-1:0] thr_mem [C*K];
    logic [LevelWidth-1:0]    level;
    logic [TreeDepth-1:0]     node;
    logic [TreeDepth-1:0]     k;
    logic [CAddrWidth-1:0]    c;
    logic [DataTypeWidth-1:0] thr_rd;
    logic                     decision;

    // Maps FP16 to an unsigned key whose integer order matches numeric order (-0 folded into +0).
    function automatic logic [DataTypeWidth-1:0] order_key(input logic [DataTypeWidth-1:0] v);
        logic [DataTypeWidth-1:0] n;
        n = (v == SignMask) ? '0 : v;
        if (n[DataTypeWidth-1]) begin
            return ~n;
        end
        return n | SignMask;
    endfunction

    assign thr_rd   = thr_mem[{c, node}];
    assign decision = order_key(x_reg[level]) > order_key(thr_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid_i) state_next = WALK;
            WALK: if (level == LastLevel) state_next = OUT;
            OUT:  if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level <= '0;
            node  <= '0;
            k     <= '0;
            c     <= '0;
            for (int i = 0; i < TreeDepth; i++) begin
                x_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        for (int i = 0; i < TreeDepth; i++) begin
                            x_reg[i] <= x_i[i*DataTypeWidth +: DataTypeWidth];
                        end
                        level <= '0;
                        node  <= '0;
                        k     <= '0;
                    end
                end
                WALK: begin
                    // Heap child is 2*node+1+b; the wrap on the final level is never used for addressing.
                    node  <= {node[TreeDepth-2:0], 1'b0} + TreeDepth'(1) + TreeDepth'(decision);
                    k     <= {k[TreeDepth-2:0], decision};
                    level <= level + LevelWidth'(1);
                end
                OUT: begin
                    if (ready_i) begin
                        c <= (c == LastC) ? '0 : c + CAddrWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < C * K; i++) begin
                thr_mem[i] <= '0;
            end
        end else if (we_i) begin
            thr_mem[waddr_i] <= wdata_i;
        end
    end

    assign in_ready_o = (state == IDLE);
    assign valid_o    = (state == OUT);
    assign c_addr_o   = c;
    assign k_addr_o   = k;
    assign last_o     = (state == OUT) && (c == LastC);

endmodule

// File: tb/tb_halut_encoder.sv
// Directed bench for halut_encoder: tree-walk results, FP16 ordering corners,
// back-pressure, streaming wrap-around and mid-walk reset.
module tb_halut_encoder;

    localparam int K  = 16;
    localparam int C  = 32;
    localparam int DW = 16;
    localparam int TD = 4;
    localparam int CW = 5;
    localparam int AW = 9;

    logic          clk;
    logic          rst_i;
    logic [AW-1:0] waddr_i;
    logic [DW-1:0] wdata_i;
    logic          we_i;
    logic [TD*DW-1:0] x_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [CW-1:0] c_addr_o;
    logic [TD-1:0] k_addr_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;

    int check_count = 0;
    int pass_count  = 0;

    halut_encoder #(
        .K(K),
        .C(C),
        .DataTypeWidth(DW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .waddr_i(waddr_i),
        .wdata_i(wdata_i),
        .we_i(we_i),
        .x_i(x_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .c_addr_o(c_addr_o),
        .k_addr_o(k_addr_o),
        .valid_o(valid_o),
        .last_o(last_o),
        .ready_i(ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    function automatic logic [TD*DW-1:0] pack4(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                                               input logic [DW-1:0] x2, input logic [DW-1:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic writeThr(input int cb, input int nd, input logic [DW-1:0] val);
        @(negedge clk);
        waddr_i = AW'(cb * K + nd);
        wdata_i = val;
        we_i    = 1'b1;
        @(negedge clk);
        we_i    = 1'b0;
    endtask

    // Offers one input while idle and returns edges from the accepting edge until valid_o.
    task automatic applyStimulus(input logic [TD*DW-1:0] x, output int latency);
        @(negedge clk);
        x_i        = x;
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        latency    = 0;
        while (!valid_o && latency < 50) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic completeCodebook();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic runCodebook(input string tag, input logic [TD*DW-1:0] x, input int exp_c, input int exp_k);
        int lat;
        checkOutput({tag, "_in_ready"}, 32'(in_ready_o), 1);
        applyStimulus(x, lat);
        checkOutput({tag, "_latency"}, 32'(lat), TD);
        checkOutput({tag, "_c_addr"}, 32'(c_addr_o), exp_c);
        checkOutput({tag, "_k_addr"}, 32'(k_addr_o), exp_k);
        checkOutput({tag, "_last"}, 32'(last_o), 0);
        completeCodebook();
    endtask

    initial begin
        int seen;
        int exp_c;
        int cyc;
        int last_cyc;

        rst_i      = 1'b1;
        waddr_i    = '0;
        wdata_i    = '0;
        we_i       = 1'b0;
        x_i        = '0;
        in_valid_i = 1'b0;
        ready_i    = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        checkOutput("reset_in_ready", 32'(in_ready_o), 1);
        checkOutput("reset_valid", 32'(valid_o), 0);
        checkOutput("reset_c_addr", 32'(c_addr_o), 0);
        checkOutput("reset_k_addr", 32'(k_addr_o), 0);
        checkOutput("reset_last", 32'(last_o), 0);

        // T1: zero thresholds, +1.0 everywhere takes the right branch at every level
        runCodebook("t1", pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 0, 15);
        checkOutput("t1_after_valid", 32'(valid_o), 0);
        checkOutput("t1_after_in_ready", 32'(in_ready_o), 1);

        // T2: -1.0 goes left everywhere
        runCodebook("t2_neg", pack4(16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00), 1, 0);

        // T2: x==thr at root -> 0, -0 vs +0 -> 0, then 1,1 -> k=0011
        writeThr(2, 0, 16'h3C00);
        runCodebook("t2_eq", pack4(16'h3C00, 16'h8000, 16'h3C00, 16'h3C00), 2, 3);

        // T3: 1.5 < 2.0 at root -> nodes 0,1,4,10 -> k=0111
        writeThr(3, 0, 16'h4000);
        runCodebook("t3", pack4(16'h3E00, 16'h3C00, 16'h3C00, 16'h3C00), 3, 7);

        // Negative ordering: -2 < -1, -1 < 0, 1 > 0, +0 == 0 -> k=0010
        writeThr(4, 0, 16'hBC00);
        runCodebook("neg_order", pack4(16'hC000, 16'hBC00, 16'h3C00, 16'h0000), 4, 2);

        // T5: back-pressure holds the result and blocks new input
        begin
            int lat;
            applyStimulus(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), lat);
            checkOutput("t5_latency", 32'(lat), TD);
            x_i        = pack4(16'hBC00, 16'hBC00, 16'hBC00, 16'hBC00);
            in_valid_i = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checkOutput("t5_hold_valid", 32'(valid_o), 1);
                checkOutput("t5_hold_c_addr", 32'(c_addr_o), 5);
                checkOutput("t5_hold_k_addr", 32'(k_addr_o), 15);
                checkOutput("t5_hold_last", 32'(last_o), 0);
                checkOutput("t5_hold_in_ready", 32'(in_ready_o), 0);
            end
            in_valid_i = 1'b0;
            completeCodebook();
            checkOutput("t5_release_in_ready", 32'(in_ready_o), 1);
        end

        // T6: reset during level 2 of codebook 6 aborts the walk
        @(negedge clk);
        x_i        = pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        checkOutput("t6_walk_in_ready", 32'(in_ready_o), 0);
        checkOutput("t6_walk_c_addr", 32'(c_addr_o), 6);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checkOutput("t6_valid", 32'(valid_o), 0);
        checkOutput("t6_in_ready", 32'(in_ready_o), 1);
        checkOutput("t6_c_addr", 32'(c_addr_o), 0);

        // T4: stream 33 inputs; cleared thresholds give k=15 everywhere (c=2,3,4 included)
        seen       = 0;
        exp_c      = 0;
        cyc        = 0;
        last_cyc   = -1;
        x_i        = pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        in_valid_i = 1'b1;
        ready_i    = 1'b1;
        while (seen < 33 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (valid_o) begin
                checkOutput("t4_c_addr", 32'(c_addr_o), exp_c);
                checkOutput("t4_k_addr", 32'(k_addr_o), 15);
                checkOutput("t4_last", 32'(last_o), (exp_c == C - 1) ? 1 : 0);
                if (last_cyc >= 0) begin
                    checkOutput("t4_spacing", 32'(cyc - last_cyc), TD + 2);
                end
                last_cyc = cyc;
                seen++;
                exp_c = (exp_c + 1) % C;
                if (seen == 33) in_valid_i = 1'b0;
            end
        end
        checkOutput("t4_result_count", 32'(seen), 33);
        ready_i    = 1'b0;
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
